id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction decode stage; consumes the IF/ID pair (PC+4, instruction) and drives branch feedback (br_taken, br_addr, if_flush) back to fetch.
- Holds the 32x32 register file with a writeback port.
- Resolves BEZ/BNE/JMP in decode; registers decoded operands and controls into the ID/EX pipeline register.

Parameters:
- REG_COUNT, 32, number of architectural registers; r0 reads as 0.
- IMM_SHIFT, 2, left shift applied to the sign-extended immediate for branch targets.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- pc_in  in  32  PC+4 of the instruction in decode
- instruction  in  32  instruction word from IF/ID
- wb_en  in  1  writeback enable
- wb_dest  in  5  writeback register index
- wb_value  in  32  writeback data
- br_taken  out  1  combinational; fetch selects br_addr next cycle
- br_addr  out  32  combinational branch target
- if_flush  out  1  combinational; equals br_taken; kills the IF/ID entry
- ex_pc  out  32  registered pc_in
- ex_val1  out  32  registered src1 value
- ex_val2  out  32  registered src2 value or sign-extended imm
- ex_st_val  out  32  registered store data
- ex_dest  out  5  registered destination index
- ex_cmd  out  4  registered ALU command
- ex_mem_r  out  1  registered load flag
- ex_mem_w  out  1  registered store flag
- ex_wb_en  out  1  registered writeback flag

Behaviour:
- Fields:
  - op=[31:26], rs1=[25:21], rs2/rt=[20:16], rd=[15:11], imm=[15:0].
  - imm is sign-extended to 32 bits.
- Opcodes (op -> ex_cmd, wb):
  - NOP 000000 -> 1111, wb0
  - ADD 000001 -> 0000
  - SUB 000011 -> 0010
  - AND 000101 -> 0100
  - OR 000110 -> 0101
  - NOR 000111 -> 0110
  - XOR 001000 -> 0111
  - SLA 001001 -> 1000
  - SLL 001010 -> 1001
  - SRA 001011 -> 1010
  - SRL 001100 -> 1011
  - ADDI 100000 -> 0000
  - SUBI 100001 -> 0010
  - LD 100100 -> 0000, mem_r, wb1
  - ST 100101 -> 0000, mem_w, wb0
  - BEZ 101000, BNE 101001, JMP 101010 -> 1111, wb0
  - Any other op is a NOP.
- Destination and operands:
  - R-type: dest=rd, val2=R[rs2].
  - ADDI/SUBI/LD: dest=rt, val2=sext(imm).
  - ST: val2=sext(imm), st_val=R[rt].
- ex_wb_en = 0 whenever dest resolves to r0.
- Register file:
  - Written on rising clk when wb_en=1 and wb_dest!=0; writes to r0 are ignored.
  - Reads are combinational, with bypass: if wb_en=1 and wb_dest equals the read index (nonzero), the read returns wb_value in the same cycle.
- Branches:
  - br_addr = pc_in + (sext(imm) << IMM_SHIFT), 32-bit wrap-around.
  - br_taken is asserted for: BEZ when R[rs1]==0; BNE when R[rs1]!=R[rt]; JMP always. Comparisons use bypassed values.
  - Branch instructions enter ID/EX as a bubble: all ex_* flags 0, ex_cmd=1111.
- Latency: 1 cycle, instruction in -> ex_* outputs. Branch feedback is 0 cycles (combinational).
- ID/EX register: captures every rising clk. There is no stall input, and hazards are handled by software NOPs.
- Reset (asynchronous):
  - All ex_* outputs go to 0 and ex_cmd to 1111.
  - All registers are cleared to 0.
  - br_taken follows the decode of the current inputs. Asserting reset mid-operation discards the in-flight ID/EX entry immediately.

Test Plan:
- Reset, then instruction=ADDI r1,r0,1546 (0x8001060A) -> next cycle ex_val1=0, ex_val2=1546, ex_dest=1, ex_cmd=0000, ex_wb_en=1.
- wb_en=1, wb_dest=1, wb_value=5 in the same cycle as ADD r2,r0,r1 -> ex_val2=5 via bypass; one cycle later R[1]=5 persists.
- BEZ r5,1 with R[5]=0, pc_in=92 -> br_taken=1, if_flush=1, br_addr=96, next ex_wb_en=0; repeated with R[5]=7 -> br_taken=0.
- BNE r1,r3 with R[1]=3, R[3]=3 -> br_taken=0; with R[3]=2 -> br_taken=1, br_addr=pc_in-656 for imm=0xFF5C.
- ST r2,r1,0 with R[1]=1024, R[2]=0xAB -> ex_mem_w=1, ex_val1=1024, ex_val2=0, ex_st_val=0xAB, ex_wb_en=0. Writeback of 9 to r0 -> R[0] still reads 0.
- Assert rst asynchronously mid-cycle during an ADD -> ex_* outputs clear without waiting for a clock edge. Undefined op 111111 -> bubble.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: instruction decode with register file, branch resolution and ID/EX pipeline register
module id_stage #(
  parameter int REG_COUNT = 32,
  parameter int IMM_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] instruction,
  input  logic        wb_en,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_value,
  output logic        br_taken,
  output logic [31:0] br_addr,
  output logic        if_flush,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_val1,
  output logic [31:0] ex_val2,
  output logic [31:0] ex_st_val,
  output logic [4:0]  ex_dest,
  output logic [3:0]  ex_cmd,
  output logic        ex_mem_r,
  output logic        ex_mem_w,
  output logic        ex_wb_en
);
  logic [31:0] regs [REG_COUNT];
  logic [5:0]  op;
  logic [4:0]  rs1, rt, rd, dest;
  logic [31:0] sext, val1, valt;
  logic [3:0]  cmd;
  logic        r_type, i_type, ld, st, bez, bne, jmp, wb;

  assign op   = instruction[31:26];
  assign rs1  = instruction[25:21];
  assign rt   = instruction[20:16];
  assign rd   = instruction[15:11];
  assign sext = {{16{instruction[15]}}, instruction[15:0]};

  // reads bypass the writeback port so a same-cycle write is visible
  assign val1 = rs1 == 5'd0 ? 32'd0 : (wb_en && wb_dest == rs1) ? wb_value : regs[rs1];
  assign valt = rt == 5'd0 ? 32'd0 : (wb_en && wb_dest == rt) ? wb_value : regs[rt];

  always_comb begin
    cmd = 4'b1111;
    r_type = 1'b0;
    i_type = 1'b0;
    ld = 1'b0;
    st = 1'b0;
    bez = 1'b0;
    bne = 1'b0;
    jmp = 1'b0;
    case (op)
      6'b000001: begin cmd = 4'b0000; r_type = 1'b1; end
      6'b000011: begin cmd = 4'b0010; r_type = 1'b1; end
      6'b000101: begin cmd = 4'b0100; r_type = 1'b1; end
      6'b000110: begin cmd = 4'b0101; r_type = 1'b1; end
      6'b000111: begin cmd = 4'b0110; r_type = 1'b1; end
      6'b001000: begin cmd = 4'b0111; r_type = 1'b1; end
      6'b001001: begin cmd = 4'b1000; r_type = 1'b1; end
      6'b001010: begin cmd = 4'b1001; r_type = 1'b1; end
      6'b001011: begin cmd = 4'b1010; r_type = 1'b1; end
      6'b001100: begin cmd = 4'b1011; r_type = 1'b1; end
      6'b100000: begin cmd = 4'b0000; i_type = 1'b1; end
      6'b100001: begin cmd = 4'b0010; i_type = 1'b1; end
      6'b100100: begin cmd = 4'b0000; i_type = 1'b1; ld = 1'b1; end
      6'b100101: begin cmd = 4'b0000; st = 1'b1; end
      6'b101000: bez = 1'b1;
      6'b101001: bne = 1'b1;
      6'b101010: jmp = 1'b1;
      default: ;
    endcase
  end

  assign dest     = r_type ? rd : rt;
  assign wb       = (r_type || i_type) && dest != 5'd0;
  assign br_taken = jmp || (bez && val1 == 32'd0) || (bne && val1 != valt);
  assign if_flush = br_taken;
  assign br_addr  = pc_in + (sext << IMM_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wb_en && wb_dest != 5'd0) begin
      regs[wb_dest] <= wb_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_pc <= '0;
      ex_val1 <= '0;
      ex_val2 <= '0;
      ex_st_val <= '0;
      ex_dest <= '0;
      ex_cmd <= 4'b1111;
      ex_mem_r <= 1'b0;
      ex_mem_w <= 1'b0;
      ex_wb_en <= 1'b0;
    end else begin
      ex_pc <= pc_in;
      ex_val1 <= val1;
      ex_val2 <= r_type ? valt : sext;
      ex_st_val <= valt;
      ex_dest <= dest;
      ex_cmd <= cmd;
      ex_mem_r <= ld;
      ex_mem_w <= st;
      ex_wb_en <= wb;
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: randomized and directed checks of id_stage against a behavioural decode model
module tb_id_stage;
  logic        clk = 0, rst = 1;
  logic [31:0] pc_in = 0, instruction = 0, wb_value = 0;
  logic        wb_en = 0;
  logic [4:0]  wb_dest = 0;
  logic        br_taken, if_flush, ex_mem_r, ex_mem_w, ex_wb_en;
  logic [31:0] br_addr, ex_pc, ex_val1, ex_val2, ex_st_val;
  logic [4:0]  ex_dest;
  logic [3:0]  ex_cmd;
  int n_checks = 0, n_fail = 0;
  logic [31:0] rf [32];
  logic        e_br, e_valid, e_st, e_ld, e_wb;
  logic [31:0] e_addr, e_val1, e_val2, e_st_val, e_pc;
  logic [4:0]  e_dest;
  logic [3:0]  e_cmd;
  logic        is_branch;

  id_stage dut (.clk(clk), .rst(rst), .pc_in(pc_in), .instruction(instruction), .wb_en(wb_en),
    .wb_dest(wb_dest), .wb_value(wb_value), .br_taken(br_taken), .br_addr(br_addr), .if_flush(if_flush),
    .ex_pc(ex_pc), .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_st_val(ex_st_val), .ex_dest(ex_dest),
    .ex_cmd(ex_cmd), .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w), .ex_wb_en(ex_wb_en));

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    return {op, a, b, d, 11'd0};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b, input logic [15:0] imm);
    return {op, a, b, imm};
  endfunction

  function automatic logic [31:0] rd_m(input logic [4:0] i);
    if (i == 0) return 0;
    if (wb_en && wb_dest == i) return wb_value;
    return rf[i];
  endfunction

  task automatic predict();
    logic [5:0] op = instruction[31:26];
    logic [31:0] a = rd_m(instruction[25:21]), b = rd_m(instruction[20:16]);
    logic signed [31:0] sx = 32'(signed'(instruction[15:0]));
    int kind;
    kind = 0;
    e_cmd = 4'b1111;
    case (op)
      6'd1: begin kind = 1; e_cmd = 0; end
      6'd3: begin kind = 1; e_cmd = 2; end
      6'd5: begin kind = 1; e_cmd = 4; end
      6'd6: begin kind = 1; e_cmd = 5; end
      6'd7: begin kind = 1; e_cmd = 6; end
      6'd8: begin kind = 1; e_cmd = 7; end
      6'd9: begin kind = 1; e_cmd = 8; end
      6'd10: begin kind = 1; e_cmd = 9; end
      6'd11: begin kind = 1; e_cmd = 10; end
      6'd12: begin kind = 1; e_cmd = 11; end
      6'd32, 6'd33: begin kind = 2; e_cmd = (op == 6'd32) ? 4'd0 : 4'd2; end
      6'd36: begin kind = 3; e_cmd = 0; end
      6'd37: begin kind = 4; e_cmd = 0; end
      6'd40: kind = 5;
      6'd41: kind = 6;
      6'd42: kind = 7;
      default: kind = 0;
    endcase
    e_valid = kind >= 1 && kind <= 4;
    is_branch = kind >= 5;
    e_ld = kind == 3;
    e_st = kind == 4;
    e_dest = kind == 1 ? instruction[15:11] : instruction[20:16];
    e_wb = kind >= 1 && kind <= 3 && e_dest != 0;
    e_val1 = a;
    e_val2 = kind == 1 ? b : sx;
    e_st_val = b;
    e_pc = pc_in;
    e_br = kind == 7 || (kind == 5 && a == 0) || (kind == 6 && a != b);
    e_addr = pc_in + sx * 4;
  endtask

  task automatic step();
    @(posedge clk);
    if (wb_en && wb_dest != 0) rf[wb_dest] = wb_value;
    #1;
  endtask

  task automatic wr(input logic [4:0] i, input logic [31:0] v);
    instruction = 0;
    wb_en = 1; wb_dest = i; wb_value = v;
    step();
    wb_en = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) rf[i] = 0;
    #12;
    n_checks++;
    if ({ex_cmd, ex_mem_r, ex_mem_w, ex_wb_en, ex_dest} !== {4'b1111, 3'b000, 5'd0} || {ex_pc, ex_val1, ex_val2, ex_st_val} !== 128'd0) begin
      n_fail++; $display("FAIL reset: cmd=%b flags=%b%b%b val1=%h val2=%h required cmd=1111 flags=000 vals=0", ex_cmd, ex_mem_r, ex_mem_w, ex_wb_en, ex_val1, ex_val2);
    end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    instruction = 32'h8001060A; pc_in = 32'd40;
    step();
    n_checks++;
    if ({ex_val1, ex_val2, ex_dest, ex_cmd, ex_wb_en, ex_mem_r, ex_mem_w} !== {32'd0, 32'd1546, 5'd1, 4'b0000, 3'b100}) begin
      n_fail++; $display("FAIL addi: val1=%0d val2=%0d dest=%0d cmd=%b wb=%b required 0 1546 1 0000 1", ex_val1, ex_val2, ex_dest, ex_cmd, ex_wb_en);
    end
  endtask

  task automatic test_bypass();
    wb_en = 1; wb_dest = 1; wb_value = 5;
    instruction = rtype(6'd1, 0, 1, 2);
    step();
    n_checks++;
    if (ex_val2 !== 32'd5 || ex_dest !== 5'd2 || ex_wb_en !== 1'b1) begin
      n_fail++; $display("FAIL bypass: val2=%0d dest=%0d wb=%b required 5 2 1", ex_val2, ex_dest, ex_wb_en);
    end
    wb_en = 0;
    step();
    n_checks++;
    if (ex_val2 !== 32'd5) begin
      n_fail++; $display("FAIL persist: val2=%0d required 5", ex_val2);
    end
  endtask

  task automatic test_bez();
    wr(5, 0);
    instruction = itype(6'b101000, 5, 0, 16'd1); pc_in = 92;
    #1;
    n_checks++;
    if ({br_taken, if_flush, br_addr} !== {2'b11, 32'd96}) begin
      n_fail++; $display("FAIL bez_taken: br=%b flush=%b addr=%0d required 1 1 96", br_taken, if_flush, br_addr);
    end
    step();
    n_checks++;
    if ({ex_wb_en, ex_mem_r, ex_mem_w, ex_cmd} !== {3'b000, 4'b1111}) begin
      n_fail++; $display("FAIL bez_bubble: flags=%b%b%b cmd=%b required 000 1111", ex_wb_en, ex_mem_r, ex_mem_w, ex_cmd);
    end
    wr(5, 7);
    instruction = itype(6'b101000, 5, 0, 16'd1);
    #1;
    n_checks++;
    if ({br_taken, if_flush} !== 2'b00) begin
      n_fail++; $display("FAIL bez_not_taken: br=%b flush=%b required 0 0", br_taken, if_flush);
    end
  endtask

  task automatic test_bne();
    wr(1, 3); wr(3, 3);
    instruction = itype(6'b101001, 1, 3, 16'hFF5C); pc_in = 1000;
    #1;
    n_checks++;
    if (br_taken !== 1'b0) begin
      n_fail++; $display("FAIL bne_equal: br=%b required 0", br_taken);
    end
    wr(3, 2);
    instruction = itype(6'b101001, 1, 3, 16'hFF5C);
    #1;
    n_checks++;
    if ({br_taken, br_addr} !== {1'b1, 32'd344}) begin
      n_fail++; $display("FAIL bne_taken: br=%b addr=%0d required 1 344", br_taken, br_addr);
    end
  endtask

  task automatic test_store();
    wr(1, 1024); wr(2, 32'hAB);
    instruction = itype(6'b100101, 1, 2, 16'd0);
    step();
    n_checks++;
    if ({ex_mem_w, ex_mem_r, ex_wb_en, ex_val1, ex_val2, ex_st_val, ex_cmd} !== {3'b100, 32'd1024, 32'd0, 32'hAB, 4'b0000}) begin
      n_fail++; $display("FAIL store: mw=%b mr=%b wb=%b val1=%0d val2=%0d st=%h cmd=%b required 1 0 0 1024 0 ab 0000", ex_mem_w, ex_mem_r, ex_wb_en, ex_val1, ex_val2, ex_st_val, ex_cmd);
    end
  endtask

  task automatic test_r0_write();
    wb_en = 1; wb_dest = 0; wb_value = 9;
    instruction = rtype(6'd1, 0, 0, 4);
    step();
    wb_en = 0;
    step();
    n_checks++;
    if ({ex_val1, ex_val2} !== 64'd0) begin
      n_fail++; $display("FAIL r0_write: val1=%0d val2=%0d required 0 0", ex_val1, ex_val2);
    end
  endtask

  task automatic test_undefined();
    instruction = {6'b111111, 26'h3FFFFFF};
    #1;
    n_checks++;
    if (br_taken !== 1'b0) begin
      n_fail++; $display("FAIL undef_br: br=%b required 0", br_taken);
    end
    step();
    n_checks++;
    if ({ex_wb_en, ex_mem_r, ex_mem_w, ex_cmd} !== {3'b000, 4'b1111}) begin
      n_fail++; $display("FAIL undef_bubble: flags=%b%b%b cmd=%b required 000 1111", ex_wb_en, ex_mem_r, ex_mem_w, ex_cmd);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [19];
    ops = '{6'd0, 6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd32, 6'd33, 6'd36, 6'd37, 6'd40, 6'd41, 6'd42, 6'd63};
    for (int n = 0; n < 300; n++) begin
      instruction = {ops[$urandom_range(0, 18)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 11'($urandom)};
      if ($urandom_range(0, 3) == 0) instruction[31:26] = 6'($urandom);
      pc_in = $urandom;
      wb_en = 1'($urandom); wb_dest = 5'($urandom_range(0, 7));
      wb_value = $urandom_range(0, 2) == 0 ? 32'd0 : $urandom;
      #1;
      predict();
      n_checks++;
      if (br_taken !== e_br || if_flush !== e_br || (is_branch && br_addr !== e_addr)) begin
        n_fail++; $display("FAIL rand_branch %0d: br=%b flush=%b addr=%h required br=%b addr=%h", n, br_taken, if_flush, br_addr, e_br, e_addr);
      end
      step();
      n_checks++;
      if ({ex_cmd, ex_mem_r, ex_mem_w, ex_wb_en} !== {e_cmd, e_ld, e_st, e_wb}) begin
        n_fail++; $display("FAIL rand_ctrl %0d: cmd=%b mr=%b mw=%b wb=%b required %b %b %b %b", n, ex_cmd, ex_mem_r, ex_mem_w, ex_wb_en, e_cmd, e_ld, e_st, e_wb);
      end
      if (e_valid) begin
        n_checks++;
        if ({ex_pc, ex_val1, ex_val2} !== {e_pc, e_val1, e_val2} || (!e_st && ex_dest !== e_dest) || (e_st && ex_st_val !== e_st_val)) begin
          n_fail++; $display("FAIL rand_data %0d: pc=%h v1=%h v2=%h dest=%0d st=%h required %h %h %h %0d %h", n, ex_pc, ex_val1, ex_val2, ex_dest, ex_st_val, e_pc, e_val1, e_val2, e_dest, e_st_val);
        end
      end
    end
    wb_en = 0;
  endtask

  task automatic test_async_reset();
    instruction = rtype(6'd1, 1, 2, 6);
    step();
    n_checks++;
    if (ex_wb_en !== 1'b1 || ex_cmd !== 4'b0000) begin
      n_fail++; $display("FAIL pre_reset: wb=%b cmd=%b required 1 0000", ex_wb_en, ex_cmd);
    end
    #2 rst = 1;
    #1;
    for (int i = 0; i < 32; i++) rf[i] = 0;
    n_checks++;
    if ({ex_wb_en, ex_mem_r, ex_mem_w, ex_cmd, ex_val1, ex_pc} !== {3'b000, 4'b1111, 64'd0}) begin
      n_fail++; $display("FAIL async_reset: wb=%b cmd=%b val1=%h pc=%h required 0 1111 0 0", ex_wb_en, ex_cmd, ex_val1, ex_pc);
    end
    rst = 0;
    instruction = rtype(6'd1, 1, 2, 6);
    step();
    n_checks++;
    if ({ex_val1, ex_val2} !== 64'd0) begin
      n_fail++; $display("FAIL rf_cleared: val1=%h val2=%h required 0 0", ex_val1, ex_val2);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_bypass();
    test_bez();
    test_bne();
    test_store();
    test_r0_write();
    test_undefined();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
